// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg: shared constants and fetch-queue entry type                |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0004;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue: synchronous {pc, instr} FIFO with single-cycle flush    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_fetch_ctrl: PC sequencing, imem/debug arbitration, fetch queue  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int          DEPTH        = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  input  logic               dbg_req,
  input  logic [31:0]        dbg_addr,
  output logic               dbg_gnt,
  output logic [INSTR_W-1:0] dbg_rdata,
  output logic               fetch_idle
);

  logic [31:0]            pc;
  logic                   last_dbg;
  logic                   fetch_want;
  logic                   fetch_fire;
  logic                   pop;
  logic                   q_full;
  logic                   q_empty;
  logic [$clog2(DEPTH):0] q_count;
  fetch_entry_t           q_head;
  fetch_entry_t           q_push_data;
  logic                   unused_low_bits;

  assign unused_low_bits = ^{dbg_addr[1:0], redirect_pc[1:0]};

  assign pop        = out_valid && out_ready;
  assign fetch_want = !halt && !redirect_valid && (!q_full || pop);
  // Debug normally wins, but yields after one grant if fetch is waiting.
  assign dbg_gnt    = dbg_req && !reset && !(last_dbg && fetch_want);
  assign fetch_fire = fetch_want && !dbg_gnt;

  assign imem_addr  = dbg_gnt ? {dbg_addr[31:2], 2'b00} : pc;
  assign dbg_rdata  = imem_data;

  assign q_push_data = '{pc: pc, instr: imem_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      last_dbg <= 1'b0;
    end else begin
      last_dbg <= dbg_gnt;
      if (redirect_valid)  pc <= {redirect_pc[31:2], 2'b00};
      else if (fetch_fire) pc <= pc + 32'd4;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (fetch_fire),
    .push_data (q_push_data),
    .pop       (pop && !redirect_valid),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign out_valid  = !q_empty;
  assign out_pc     = q_head.pc;
  assign out_instr  = q_head.instr;
  assign fetch_idle = halt && (q_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_fetch_ctrl: random + directed bench against a queue model    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imem_fetch_ctrl;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0004;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        fetch_idle;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];
  logic [31:0] m_pc;
  logic        m_last;

  // Last sampled DUT values, used by the literal pins
  logic        obs_valid, obs_gnt, obs_idle;
  logic [31:0] obs_pc, obs_instr, obs_addr, obs_rdata;

  always #5 clock = ~clock;

  imem_fetch_ctrl #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_gnt        (dbg_gnt),
    .dbg_rdata      (dbg_rdata),
    .fetch_idle     (fetch_idle)
  );

  // Word n sits at byte address 4+4n
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2) - 32'd1;
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: settle, compare against the model, advance the model across the edge.
  task automatic cycle();
    logic        ev, pop, want, gnt;
    logic [31:0] addr;
    #1;
    ev   = (q_pc.size() != 0);
    pop  = ev && out_ready;
    want = !halt && !redirect_valid && ((q_pc.size() < DEPTH) || pop);
    gnt  = dbg_req && !reset && !(m_last && want);
    addr = gnt ? {dbg_addr[31:2], 2'b00} : m_pc;

    check("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (ev) begin
      check("out_pc", out_pc, q_pc[0]);
      check("out_instr", out_instr, q_instr[0]);
    end
    check("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, gnt});
    check("imem_addr", imem_addr, addr);
    check("fetch_idle", {31'd0, fetch_idle}, {31'd0, halt && (q_pc.size() == 0)});
    if (gnt) check("dbg_rdata", dbg_rdata, mem_word(addr));

    obs_valid = out_valid; obs_gnt = dbg_gnt; obs_idle = fetch_idle;
    obs_pc = out_pc; obs_instr = out_instr; obs_addr = imem_addr; obs_rdata = dbg_rdata;

    if (reset) begin
      q_pc.delete(); q_instr.delete();
      m_pc = RV; m_last = 1'b0;
    end else if (redirect_valid) begin
      q_pc.delete(); q_instr.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      m_last = gnt;
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_instr.pop_front());
      end
      if (want && !gnt) begin
        q_pc.push_back(m_pc);
        q_instr.push_back(mem_word(m_pc));
        m_pc = m_pc + 32'd4;
      end
      m_last = gnt;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
    halt = 0; dbg_req = 0; dbg_addr = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    q_pc.delete(); q_instr.delete();
    m_pc = RV; m_last = 1'b0;
    @(posedge clock);
    #1;
    cycle();
    check("reset_valid", {31'd0, obs_valid}, 32'd0);
    check("reset_gnt", {31'd0, obs_gnt}, 32'd0);

    // Streaming from reset
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 0) begin
        check("first_valid_low", {31'd0, obs_valid}, 32'd0);
        check("first_addr", obs_addr, 32'h4);
      end
      if (i == 1) begin
        check("first_pc", obs_pc, 32'h4);
        check("first_instr", obs_instr, 32'h1000_0000);
      end
      if (i == 2) check("second_pc", obs_pc, 32'h8);
    end

    // Back-pressure fill
    reset = 1; cycle();
    reset = 0; out_ready = 0;
    for (int i = 0; i < 5; i++) cycle();
    check("bp_pc_hold", obs_addr, 32'hC);
    check("bp_head", obs_pc, 32'h4);
    out_ready = 1;
    cycle(); check("bp_d0", obs_pc, 32'h4);
    cycle(); check("bp_d1", obs_pc, 32'h8);
    cycle(); check("bp_d2", obs_pc, 32'hC);

    // Redirect while full
    redirect_valid = 1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect_valid = 0;
    cycle(); check("redir_gap", {31'd0, obs_valid}, 32'd0);
    cycle(); check("redir_pc0", obs_pc, 32'h100);
    check("redir_instr0", obs_instr, 32'h1000_003F);
    cycle(); check("redir_pc1", obs_pc, 32'h104);

    // Debug interleave
    dbg_req = 1; dbg_addr = 32'h40;
    cycle(); check("dbg_g0", {31'd0, obs_gnt}, 32'd1);
    check("dbg_rd", obs_rdata, 32'h1000_000F);
    cycle(); check("dbg_g1", {31'd0, obs_gnt}, 32'd0);
    cycle(); check("dbg_g2", {31'd0, obs_gnt}, 32'd1);
    cycle(); check("dbg_g3", {31'd0, obs_gnt}, 32'd0);
    dbg_req = 0;

    // Halt drain
    out_ready = 0;
    for (int i = 0; i < 3; i++) cycle();
    halt = 1; out_ready = 1;
    cycle(); cycle();
    dbg_req = 1; dbg_addr = 32'h80;
    cycle();
    check("halt_idle", {31'd0, obs_idle}, 32'd1);
    check("halt_dbg_addr", obs_addr, 32'h80);
    dbg_req = 0; halt = 0;
    cycle(); cycle(); cycle();

    // Reset mid-stream with pending debug
    reset = 1; dbg_req = 1; dbg_addr = 32'h40;
    cycle(); check("rst_gnt", {31'd0, obs_gnt}, 32'd0);
    reset = 0;
    cycle(); check("rst_valid", {31'd0, obs_valid}, 32'd0);
    check("rst_retry", {31'd0, obs_gnt}, 32'd1);
    dbg_req = 0;
    cycle(); check("rst_fetch", obs_addr, 32'h4);
    cycle(); check("rst_pc", obs_pc, 32'h4);

    // PC wrap
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 0;
    cycle(); check("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
    cycle(); check("wrap_addr1", obs_addr, 32'h0);
    check("wrap_pc0", obs_pc, 32'hFFFF_FFFC);
    check("wrap_instr0", obs_instr, 32'h4FFF_FFFE);
    cycle(); check("wrap_pc1", obs_pc, 32'h0);
    check("wrap_instr1", obs_instr, 32'h0FFF_FFFF);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(63) == 0);
      out_ready      = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(9) == 0);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15)) : $urandom;
      halt           = ($urandom_range(5) == 0);
      dbg_req        = ($urandom_range(2) == 0);
      dbg_addr       = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the instruction memory: owns the PC, issues fetch addresses and buffers {pc, instruction} pairs in a small queue toward decode.
- Handles branch/jump redirects with a queue flush, a halt request, and a debug read port that shares the single memory read port.
- Sits between the instruction memory (combinational read, address in, word out the same cycle) and the decode stage.

Parameters:
- RESET_VECTOR, 32'h0000_0004, PC after reset; the first program word lives at byte address 4.
- DEPTH, 2, fetch queue entries; power of two, at least 2.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  32  byte address to instruction memory
- imem_data  in  32  word read at imem_addr, same cycle
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  32  new PC
- halt  in  1  stop issuing fetches
- dbg_req  in  1  debug read request
- dbg_addr  in  32  debug byte address
- dbg_gnt  out  1  debug read performed this cycle
- dbg_rdata  out  32  debug read data, valid when dbg_gnt
- fetch_idle  out  1  halt asserted and queue empty

Behaviour:
- Reset: pc = RESET_VECTOR, queue empty, out_valid=0, dbg_gnt=0, last_dbg=0. fetch_idle is combinational: halt && queue empty.
- Memory slot: exactly one read per cycle. imem_addr = dbg_gnt ? {dbg_addr[31:2],2'b00} : pc. dbg_rdata = imem_data, combinational.
- Arbitration: fetch_want = !halt && !redirect_valid && (count<DEPTH || (out_valid && out_ready)). dbg_gnt = dbg_req && !reset && !(last_dbg && fetch_want). Debug wins by default, but never two consecutive cycles while fetch wants the slot. last_dbg <= dbg_gnt.
- Fetch: fetch_fire = fetch_want && !dbg_gnt. On fire, push {pc, imem_data} and pc <= pc+4. PC wraps modulo 2^32.
- Pop: the head leaves when out_valid && out_ready. Push and pop in the same cycle are allowed when full; count is unchanged.
- Latency: the first fetch is in the cycle after reset drops. out_valid rises the following cycle. With out_ready=1, no halt and no debug, throughput is 1 instr/cycle.
- Redirect (highest priority): queue flushed and pc <= {redirect_pc[31:2],2'b00} at the edge. No push that cycle. A pop presented in the same cycle is considered consumed; the head is discarded with the rest. out_valid=0 the next cycle; the first new instruction is valid two cycles after redirect.
- Redirect and debug in the same cycle: debug may still be granted, since the memory slot is free.
- Halt: no new fetches; the queue drains normally. Deassertion resumes from the held pc. Redirect during halt still updates pc and flushes.
- Reset mid-operation: queue flushed, pc reloaded, debug grant dropped in the reset cycle. A pending dbg_req is retried after reset.
- out_instr/out_pc hold their last values when out_valid=0. The bench checks them only when valid.

Decomposition:
- Shared package (mips_pkg): RESET_VECTOR default, INSTR_W=32, NOP=32'h0000_0000, fetch entry typedef {pc[31:0], instr[31:0]}.
- Sub-module fetch_queue: synchronous FIFO with flush, push/pop/full/empty/count. DEPTH entries, pointer wrap via power-of-two indexing. The controller holds the PC, arbitration and redirect logic.

Test Plan:
- Reset release, memory word n at address 4+4n = 32'h1000_0000+n, out_ready=1 -> out_pc 4,8,12,… on consecutive cycles, out_instr matches, first valid one cycle after the first fetch.
- out_ready=0 for 5 cycles -> queue fills to DEPTH (entries pc 4,8), imem fetch stops, pc holds at 12; ready=1 -> 4,8,12 delivered with no gap or duplicate.
- Redirect to 32'h0000_0103 while queue full -> queue flushed, out_valid=0 one cycle, next out_pc=32'h0000_0100 and then 0x104.
- dbg_req held 4 cycles at 0x40 during streaming -> dbg_gnt pattern 1,0,1,0, dbg_rdata = word at 0x40 on grant cycles, instruction stream in order without loss.
- halt=1 with 2 queued -> both drain, fetch_idle=1, imem_addr driven only by debug; halt=0 -> resume at held pc.
- reset asserted mid-stream with dbg_req=1 -> next cycle out_valid=0, dbg_gnt=0 during reset, fetch restarts at 4; pc wrap: redirect to 32'hFFFF_FFFC -> next pc 0.
